dtree_mc: RTL and testbench

DTREE_MC -- requirements
Module: dtree_mc

---
 rtl/dtree_mc_pkg.sv | 22 ++
 rtl/dtree_mc_mac.sv | 62 ++++++
 rtl/dtree_mc.sv | 156 +++++++++++++++
 tb/tb_dtree_mc.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dtree_mc_pkg.sv
// Shared definitions for the multi-channel oblique decision tree evaluator:
// controller states, bias term index and the Q-format product shift.
package dtree_mc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        BIAS,
        MAC,
        DECIDE,
        DONE
    } state_t;

    localparam int TERM_BIAS = 0;

    // Arithmetic shift drops the fraction bits, rounding toward minus infinity.
    function automatic logic signed [63:0] q_shift(input logic signed [63:0] prod,
                                                   input int unsigned     frac_bits);
        return prod >>> frac_bits;
    endfunction

endpackage

// File: rtl/dtree_mc_mac.sv
// Node evaluator datapath: term selection, Q-format multiply and the accumulator.
// Define DTREE_MC_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module dtree_mc_mac
    import dtree_mc_pkg::*;
#(
    parameter int IN_WIDTH    = 10,
    parameter int COEFF_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_bias,
    input  logic                   mac_en,
    input  logic [IN_WIDTH-1:0]    bias,
    input  logic [IN_WIDTH-1:0]    sample,
    input  logic [COEFF_WIDTH:0]   coeff_word,
    output logic                   acc_neg,
    output logic                   ovf
);

    localparam int ACC_W  = IN_WIDTH + 2;
    localparam int PROD_W = IN_WIDTH + COEFF_WIDTH;

    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  term;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  sample_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W:0]    sum;

    function automatic logic signed [ACC_W-1:0] acc_update(input logic signed [ACC_W:0] s);
`ifdef DTREE_MC_SAT_EN
        if (s[ACC_W] != s[ACC_W-1])
            return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        return s[ACC_W-1:0];
`else
        return s[ACC_W-1:0];
`endif
    endfunction

    assign bias_ext   = $signed({{2{bias[IN_WIDTH-1]}}, bias});
    assign sample_ext = $signed({{2{sample[IN_WIDTH-1]}}, sample});
    assign prod = $signed({{COEFF_WIDTH{sample[IN_WIDTH-1]}}, sample})
                * $signed({{IN_WIDTH{coeff_word[COEFF_WIDTH-1]}}, coeff_word[COEFF_WIDTH-1:0]});

    // is_one bypasses the multiplier so a unit weight is exact.
    assign term = coeff_word[COEFF_WIDTH] ? sample_ext
                : ACC_W'(q_shift({{(64-PROD_W){prod[PROD_W-1]}}, prod}, COEFF_WIDTH - 1));

    assign sum     = {acc[ACC_W-1], acc} + {term[ACC_W-1], term};
    assign ovf     = mac_en && (sum[ACC_W] != sum[ACC_W-1]);
    assign acc_neg = acc[ACC_W-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            acc <= '0;
        else if (load_bias)
            acc <= bias_ext;
        else if (mac_en)
            acc <= acc_update(sum);
    end

endmodule

// File: rtl/dtree_mc.sv
// Multi-channel oblique decision tree: buffers a feature vector, walks DEPTH levels
// of bias + weighted-sum nodes and reports the leaf. Optional macro: DTREE_MC_SAT_EN.
module dtree_mc
    import dtree_mc_pkg::*;
#(
    parameter int FEATURES    = 3,
    parameter int DEPTH       = 2,
    parameter int IN_WIDTH    = 10,
    parameter int COEFF_WIDTH = 4,
    parameter int CHANNELS    = 2,
    localparam int NODES      = (1 << DEPTH) - 1,
    localparam int WORDS      = CHANNELS * NODES * (FEATURES + 1),
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int ADDR_W     = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_WIDTH-1:0] sample,
    input  logic [CH_W-1:0]     in_ch,
    input  logic                cfg_we,
    input  logic [ADDR_W-1:0]   cfg_addr,
    input  logic [IN_WIDTH-1:0] cfg_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DEPTH-1:0]    out_leaf,
    output logic [CH_W-1:0]     out_ch,
    output logic                out_ovf
);

    localparam int FEAT_W = (FEATURES > 1) ? $clog2(FEATURES) : 1;
    localparam int LVL_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NODE_W = DEPTH + 1;

    state_t              state, state_nx;
    logic [FEAT_W-1:0]   beat_cnt, mac_idx;
    logic [LVL_W-1:0]    level;
    logic [NODE_W-1:0]   node, child;
    logic [CH_W-1:0]     cur_ch;
    logic [IN_WIDTH-1:0] mem  [WORDS];
    logic [IN_WIDTH-1:0] vbuf [FEATURES];
    logic [ADDR_W-1:0]   rd_addr;
    logic [IN_WIDTH-1:0] rd_word;
    int                  term_idx;
    logic                accept, last_beat, last_term, last_level;
    logic                acc_neg, step_ovf, cfg_hit;

    assign in_ready   = (state == IDLE) || (state == LOAD);
    assign out_valid  = (state == DONE);
    assign accept     = in_valid && in_ready;
    assign last_beat  = (beat_cnt == FEAT_W'(FEATURES - 1));
    assign last_term  = (mac_idx == FEAT_W'(FEATURES - 1));
    assign last_level = (level == LVL_W'(DEPTH - 1));
    assign cfg_hit    = cfg_we && in_ready && (int'(cfg_addr) < WORDS);
    assign child      = {node[NODE_W-2:0], 1'b0} + (acc_neg ? NODE_W'(2) : NODE_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (in_valid) state_nx = (FEATURES == 1) ? BIAS : LOAD;
            LOAD:    if (in_valid && last_beat) state_nx = BIAS;
            BIAS:    state_nx = MAC;
            MAC:     if (last_term) state_nx = DECIDE;
            DECIDE:  state_nx = last_level ? DONE : BIAS;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_cnt <= '0;
            mac_idx  <= '0;
            level    <= '0;
            node     <= '0;
            cur_ch   <= '0;
            out_leaf <= '0;
            out_ch   <= '0;
            out_ovf  <= 1'b0;
        end else begin
            if (accept) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
                if (state == IDLE)
                    cur_ch <= in_ch;
                if (last_beat)
                    node <= '0;
            end
            if (state == MAC)
                mac_idx <= last_term ? '0 : mac_idx + 1'b1;
            // Overflow is sticky across all levels of one evaluation.
            if (state == BIAS && level == '0)
                out_ovf <= 1'b0;
            if (step_ovf)
                out_ovf <= 1'b1;
            if (state == DECIDE) begin
                if (last_level) begin
                    level    <= '0;
                    node     <= '0;
                    out_leaf <= DEPTH'(child - NODE_W'(NODES));
                    out_ch   <= cur_ch;
                end else begin
                    level <= level + 1'b1;
                    node  <= child;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WORDS; i++)
                mem[i] <= '0;
        end else if (cfg_hit) begin
            mem[cfg_addr] <= cfg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            vbuf[beat_cnt] <= sample;
    end

    // Word layout: ((channel * NODES) + node) * (FEATURES + 1) + term.
    always_comb begin
        term_idx = TERM_BIAS;
        if (state == MAC)
            term_idx = int'(mac_idx) + 1;
        rd_addr = ADDR_W'((int'(cur_ch) * NODES + int'(node)) * (FEATURES + 1) + term_idx);
    end

    assign rd_word = mem[rd_addr];

    dtree_mc_mac #(
        .IN_WIDTH    (IN_WIDTH),
        .COEFF_WIDTH (COEFF_WIDTH)
    ) u_mac (
        .clk        (clk),
        .reset      (reset),
        .load_bias  (state == BIAS),
        .mac_en     (state == MAC),
        .bias       (rd_word),
        .sample     (vbuf[mac_idx]),
        .coeff_word (rd_word[COEFF_WIDTH:0]),
        .acc_neg    (acc_neg),
        .ovf        (step_ovf)
    );

endmodule

// File: tb/tb_dtree_mc.sv
// Self-checking bench for dtree_mc: vector table with a result scoreboard plus
// reset, back-pressure and overflow sequences (second instance with FEATURES=4).
module tb_dtree_mc;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_ready, cfg_we, out_valid, out_ready, out_ovf;
    logic [9:0] sample, cfg_data;
    logic [0:0] in_ch, out_ch;
    logic [4:0] cfg_addr;
    logic [1:0] out_leaf;

    logic       d4_in_valid, d4_in_ready, d4_cfg_we, d4_out_valid, d4_out_ovf;
    logic [9:0] d4_sample, d4_cfg_data;
    logic [0:0] d4_in_ch, d4_out_ch;
    logic [4:0] d4_cfg_addr;
    logic [1:0] d4_out_leaf;

    typedef struct { logic ch; int s0; int s1; int s2; int leaf; } vec_t;
    typedef struct { int leaf; int ch; int ovf; } exp_t;

    vec_t tbl [15];
    exp_t sb  [$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    dtree_mc u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .sample(sample), .in_ch(in_ch), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_leaf(out_leaf), .out_ch(out_ch), .out_ovf(out_ovf)
    );

    dtree_mc #(.FEATURES(4)) u_dut4 (
        .clk(clk), .reset(reset), .in_valid(d4_in_valid), .in_ready(d4_in_ready),
        .sample(d4_sample), .in_ch(d4_in_ch), .cfg_we(d4_cfg_we), .cfg_addr(d4_cfg_addr),
        .cfg_data(d4_cfg_data), .out_valid(d4_out_valid), .out_ready(1'b1),
        .out_leaf(d4_out_leaf), .out_ch(d4_out_ch), .out_ovf(d4_out_ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cfg_write(input int addr, input int data);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = 5'(addr);
        cfg_data = 10'(data);
        @(posedge clk);
        #1 cfg_we = 1'b0;
    endtask

    task automatic send3(input logic ch, input int s0, input int s1, input int s2);
        int sv [3];
        sv = '{s0, s1, s2};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            sample   = 10'(sv[i]);
            in_ch    = ch;
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
    endtask

    // Called 1 time unit after the last beat's accepting edge.
    task automatic wait_result(input string name, input int lat);
        int   cyc;
        exp_t e;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 200) begin
            @(posedge clk);
            #1 cyc++;
        end
        check({name, "_latency"}, cyc, lat);
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_scoreboard: got a result, expected none queued", name);
        end else begin
            e = sb.pop_front();
            check({name, "_leaf"}, out_leaf, e.leaf);
            check({name, "_ch"},   out_ch,   e.ch);
            check({name, "_ovf"},  out_ovf,  e.ovf);
        end
    endtask

    task automatic d4_cfg(input int addr, input int data);
        @(negedge clk);
        d4_cfg_we   = 1'b1;
        d4_cfg_addr = 5'(addr);
        d4_cfg_data = 10'(data);
        @(posedge clk);
        #1 d4_cfg_we = 1'b0;
    endtask

    task automatic d4_run(input string name, input int s, input int leaf, input int ovf);
        int cyc;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            d4_in_valid = 1'b1;
            d4_sample   = 10'(s);
            d4_in_ch    = 1'b0;
            @(posedge clk);
        end
        #1 d4_in_valid = 1'b0;
        cyc = 0;
        while (d4_out_valid !== 1'b1 && cyc < 200) begin
            @(posedge clk);
            #1 cyc++;
        end
        check({name, "_latency"}, cyc, 12);
        check({name, "_leaf"}, d4_out_leaf, leaf);
        check({name, "_ch"},   d4_out_ch,   0);
        check({name, "_ovf"},  d4_out_ovf,  ovf);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b0,    1,   2,  3, 1};
        tbl[1]  = '{1'b1,  100,   0,  0, 2};
        tbl[2]  = '{1'b1,  101, 200,  0, 0};
        tbl[3]  = '{1'b1,  101, 202, -3, 1};
        tbl[4]  = '{1'b1,  101, 201,  0, 0};
        tbl[5]  = '{1'b1,  101, 199,  0, 1};
        tbl[6]  = '{1'b0, -512, 511, -1, 1};
        tbl[7]  = '{1'b1, -512,   0,  0, 2};
        tbl[8]  = '{1'b0,    5,   1,  0, 2};
        tbl[9]  = '{1'b0,    5,   0,  0, 1};
        tbl[10] = '{1'b0,    4,   8,  0, 1};
        tbl[11] = '{1'b0,    4,   9,  0, 2};
        tbl[12] = '{1'b0,  -10, -16,  0, 1};
        tbl[13] = '{1'b0, -512,   0,  0, 1};
        tbl[14] = '{1'b1,  101, 200,  0, 0};

        reset = 1'b1;
        in_valid = 1'b0; sample = '0; in_ch = '0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; out_ready = 1'b1;
        d4_in_valid = 1'b0; d4_sample = '0; d4_in_ch = '0;
        d4_cfg_we = 1'b0; d4_cfg_addr = '0; d4_cfg_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  in_ready,  1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_leaf",  out_leaf,  0);
        check("rst_out_ch",    out_ch,    0);
        check("rst_out_ovf",   out_ovf,   0);
        @(negedge clk);
        reset = 1'b0;

        // Reset in the middle of an evaluation, then a fresh vector on cleared storage.
        cfg_write(0, 5);
        cfg_write(4, -3);
        send3(1'b0, 1, 2, 3);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        check("midmac_out_valid", out_valid, 0);
        check("midmac_in_ready",  in_ready,  1);
        reset = 1'b0;
        sb.push_back('{0, 0, 0});
        send3(1'b0, 1, 2, 3);
        wait_result("after_reset", 10);
        @(posedge clk);
        #1;

        cfg_write(0, 5);
        cfg_write(4, -3);
        cfg_write(12, -101);
        cfg_write(13, 16);
        cfg_write(16, -100);
        cfg_write(18, 4);
        cfg_write(19, 4);
        cfg_write(27, 5);

        for (int i = 0; i < 15; i++) begin
            if (i == 8) begin
                cfg_write(1, 8);
                cfg_write(2, 15);
            end
            sb.push_back('{tbl[i].leaf, int'(tbl[i].ch), 0});
            send3(tbl[i].ch, tbl[i].s0, tbl[i].s1, tbl[i].s2);
            wait_result($sformatf("vec%0d", i), 10);
            @(posedge clk);
            #1;
        end

        // Back-pressure: result held, config writes and input beats refused.
        out_ready = 1'b0;
        sb.push_back('{1, 0, 0});
        send3(1'b0, 5, 0, 0);
        wait_result("stall", 10);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("stall%0d_out_valid", k), out_valid, 1);
            check($sformatf("stall%0d_out_leaf", k),  out_leaf,  1);
            check($sformatf("stall%0d_in_ready", k),  in_ready,  0);
            if (k == 4) begin
                cfg_we = 1'b1; cfg_addr = 5'd4; cfg_data = 10'd3;
            end
            if (k == 5)
                cfg_we = 1'b0;
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        sample    = 10'd300;
        in_ch     = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("release_out_valid", out_valid, 0);
        check("release_in_ready",  in_ready,  1);
        sb.push_back('{1, 0, 0});
        send3(1'b0, 5, 0, 0);
        wait_result("post_stall", 10);
        @(posedge clk);
        #1;

        // FEATURES=4 overflow: 511 + 4*511 exceeds the 12-bit accumulator.
        d4_cfg(0, 511);
        for (int t = 1; t <= 4; t++)
            d4_cfg(t, 16);
`ifdef DTREE_MC_SAT_EN
        d4_run("ovf_run", 511, 0, 1);
`else
        d4_run("ovf_run", 511, 2, 1);
`endif
        d4_run("ovf_clear", 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
